// File: rtl/ysyx_23060124_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI4-Lite arbiter: FSM state encoding,
// response codes, owner encoding and the state-to-grant mapping.
package ysyx_23060124_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFU_RD = 2'd1,
    ARB_LSU_RD = 2'd2,
    ARB_LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] ARB_RESP_OKAY   = 2'b00;
  localparam logic [1:0] ARB_RESP_SLVERR = 2'b10;

  // Owner encoding of the last_grant flop
  localparam logic ARB_LAST_IFU = 1'b0;
  localparam logic ARB_LAST_LSU = 1'b1;

  // One-hot {LSU,IFU} owner implied by an FSM state
  function automatic logic [1:0] arb_grant_of(input arb_state_e st);
    logic [1:0] g;
    case (st)
      ARB_IFU_RD: g = 2'b01;
      ARB_LSU_RD: g = 2'b10;
      ARB_LSU_WR: g = 2'b10;
      default:    g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ysyx_23060124_rr_arb2.sv
// Two-request round-robin picker. On a tie the requester that was not
// granted last time wins; a lone requester always wins.
module ysyx_23060124_rr_arb2
  import ysyx_23060124_axi_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick one requester, alternating on ties
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == ARB_LAST_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction at a time; the owner keeps the port until its R or B
// handshake. Channels are a pure combinational mux keyed by the FSM state.
module ysyx_23060124_axi_arbiter
  import ysyx_23060124_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // IFU read
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // LSU read
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // LSU write
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // Slave port
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [1:0]        o_grant
);

  arb_state_e state, state_nxt;
  logic       last_grant;
  logic [1:0] req, gnt;

  assign req = {m1_arvalid | m1_awvalid, m0_arvalid};

  ysyx_23060124_rr_arb2 u_rr (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt)
  );

  // FSM state register; reset aborts any transaction immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remember the owner of the latest grant so the next tie goes the other way
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= ARB_LAST_LSU;
    end else if (state == ARB_IDLE && gnt != 2'b00) begin
      last_grant <= gnt[1];
    end else begin
      last_grant <= last_grant;
    end
  end

  // Next state: grant from IDLE, release on the final R or B handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (gnt[0]) begin
          state_nxt = ARB_IFU_RD;
        end else if (gnt[1]) begin
          // a simultaneous LSU read and write serves the read first
          state_nxt = m1_arvalid ? ARB_LSU_RD : ARB_LSU_WR;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_IFU_RD: state_nxt = (s_rvalid && m0_rready) ? ARB_IDLE : ARB_IFU_RD;
      ARB_LSU_RD: state_nxt = (s_rvalid && m1_rready) ? ARB_IDLE : ARB_LSU_RD;
      ARB_LSU_WR: state_nxt = (s_bvalid && m1_bready) ? ARB_IDLE : ARB_LSU_WR;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // Channel mux: only the owner's channels are connected, everything else 0
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = {DATA_W{1'b0}};
    m0_rresp   = ARB_RESP_OKAY;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = {DATA_W{1'b0}};
    m1_rresp   = ARB_RESP_OKAY;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = ARB_RESP_OKAY;
    m1_bvalid  = 1'b0;
    s_araddr   = {ADDR_W{1'b0}};
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = {ADDR_W{1'b0}};
    s_awvalid  = 1'b0;
    s_wdata    = {DATA_W{1'b0}};
    s_wstrb    = {STRB_W{1'b0}};
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    o_grant    = arb_grant_of(state);
    case (state)
      ARB_IFU_RD: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      ARB_LSU_RD: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      ARB_LSU_WR: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060124_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI4-Lite arbiter. The bench plays both
// masters and the slave; expected values are written out by hand.
module tb_ysyx_23060124_axi_arbiter;
  import ysyx_23060124_axi_arbiter_pkg::*;

  logic        i_clk, i_rst_n;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [3:0]  m1_wstrb, s_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_rresp, s_bresp, o_grant;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060124_axi_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .o_grant(o_grant)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // let combinational paths settle after an input change
  task automatic settle;
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    m0_araddr = 32'h0; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr = 32'h0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr = 32'h0; m1_awvalid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    m1_wvalid = 1'b0; m1_bready = 1'b0;
    s_arready = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;

    // ---- reset state ----
    #2;
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_s_wvalid", 64'(s_wvalid), 64'd0);
    check("rst_m1_bvalid", 64'(m1_bvalid), 64'd0);
    tick; tick;
    i_rst_n = 1'b1;
    tick;

    // ---- 1: IFU-only read ----
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1;
    settle;
    check("t1_idle_s_arvalid", 64'(s_arvalid), 64'd0);
    tick;
    s_arready = 1'b1;
    settle;
    check("t1_grant", 64'(o_grant), 64'd1);
    check("t1_s_arvalid", 64'(s_arvalid), 64'd1);
    check("t1_s_araddr", 64'(s_araddr), 64'h8000_0000);
    check("t1_m0_arready", 64'(m0_arready), 64'd1);
    check("t1_m1_arready", 64'(m1_arready), 64'd0);
    tick;
    m0_arvalid = 1'b0; s_arready = 1'b0;
    tick;
    s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
    settle;
    check("t1_m0_rvalid", 64'(m0_rvalid), 64'd1);
    check("t1_m0_rdata", 64'(m0_rdata), 64'h0000_0413);
    check("t1_m1_rvalid", 64'(m1_rvalid), 64'd0);
    check("t1_s_rready", 64'(s_rready), 64'd1);
    tick;
    s_rvalid = 1'b0;
    settle;
    check("t1_release", 64'(o_grant), 64'd0);

    // ---- 2: tie after reset, IFU first then alternating ----
    i_rst_n = 1'b0; #2; i_rst_n = 1'b1;
    tick;
    m0_araddr = 32'h8000_0004; m0_arvalid = 1'b1; m0_rready = 1'b1;
    m1_araddr = 32'h8000_1000; m1_arvalid = 1'b1; m1_rready = 1'b1;
    tick;
    settle;
    check("t2_first_ifu", 64'(o_grant), 64'd1);
    check("t2_loser_arready", 64'(m1_arready), 64'd0);
    s_arready = 1'b1;
    tick;
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_0011;
    tick;
    s_rvalid = 1'b0;
    m0_arvalid = 1'b1;               // IFU asks again: tie during the bubble
    settle;
    check("t2_bubble", 64'(o_grant), 64'd0);
    tick;
    s_arready = 1'b1;
    settle;
    check("t2_second_lsu", 64'(o_grant), 64'd2);
    check("t2_m0_arready_lost", 64'(m0_arready), 64'd0);
    check("t2_s_araddr_lsu", 64'(s_araddr), 64'h8000_1000);
    tick;
    m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_0022;
    settle;
    check("t2_m1_rdata", 64'(m1_rdata), 64'h0000_0022);
    check("t2_m0_rvalid_off", 64'(m0_rvalid), 64'd0);
    tick;
    s_rvalid = 1'b0;
    m1_arvalid = 1'b1;               // another tie: IFU's turn
    tick;
    settle;
    check("t2_third_ifu", 64'(o_grant), 64'd1);
    s_arready = 1'b1;
    tick;
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
    tick;
    s_rvalid = 1'b0;
    tick;
    settle;
    check("t2_held_lsu", 64'(o_grant), 64'd2);
    s_arready = 1'b1;
    tick;
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
    tick;
    s_rvalid = 1'b0;

    // ---- 3: LSU store, AW before W, exit only on B ----
    m1_awaddr = 32'h8000_2000; m1_awvalid = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011; m1_wvalid = 1'b1;
    m1_bready = 1'b0;
    tick;
    settle;
    check("t3_grant", 64'(o_grant), 64'd2);
    check("t3_s_awaddr", 64'(s_awaddr), 64'h8000_2000);
    check("t3_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    check("t3_s_wstrb", 64'(s_wstrb), 64'h3);
    check("t3_s_wvalid", 64'(s_wvalid), 64'd1);
    s_awready = 1'b1;
    settle;
    check("t3_m1_awready", 64'(m1_awready), 64'd1);
    check("t3_m1_wready_early", 64'(m1_wready), 64'd0);
    tick;
    m1_awvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b1;
    settle;
    check("t3_s_awvalid_done", 64'(s_awvalid), 64'd0);
    check("t3_m1_wready", 64'(m1_wready), 64'd1);
    tick;
    m1_wvalid = 1'b0; s_wready = 1'b0;
    s_rvalid = 1'b1;                 // stray read data must not leak
    settle;
    check("t3_s_wvalid_once", 64'(s_wvalid), 64'd0);
    check("t3_stray_m1_rvalid", 64'(m1_rvalid), 64'd0);
    check("t3_stray_m0_rvalid", 64'(m0_rvalid), 64'd0);
    tick;
    s_rvalid = 1'b0;
    settle;
    check("t3_hold_after_stray", 64'(o_grant), 64'd2);
    s_bvalid = 1'b1; s_bresp = 2'b00;
    tick;
    settle;
    check("t3_hold_no_bready", 64'(o_grant), 64'd2);
    m1_bready = 1'b1;
    settle;
    check("t3_m1_bvalid", 64'(m1_bvalid), 64'd1);
    check("t3_s_bready", 64'(s_bready), 64'd1);
    tick;
    s_bvalid = 1'b0;
    settle;
    check("t3_release", 64'(o_grant), 64'd0);

    // ---- 4: IFU held during a 5-cycle LSU write ----
    m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    tick;
    m0_araddr = 32'h8000_0008; m0_arvalid = 1'b1; m0_rready = 1'b1;
    s_arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        s_awready = 1'b1; s_wready = 1'b1;
      end
      if (i == 4) s_bvalid = 1'b1;
      settle;
      check("t4_m0_arready_blocked", 64'(m0_arready), 64'd0);
      check("t4_grant_lsu", 64'(o_grant), 64'd2);
      tick;
      if (i == 0) begin
        m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
      end
    end
    s_bvalid = 1'b0;
    settle;
    check("t4_bubble", 64'(o_grant), 64'd0);
    check("t4_bubble_arready", 64'(m0_arready), 64'd0);
    tick;
    settle;
    check("t4_ifu_grant", 64'(o_grant), 64'd1);
    check("t4_m0_arready", 64'(m0_arready), 64'd1);
    tick;
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
    tick;
    s_rvalid = 1'b0;

    // ---- 5: LSU read with SLVERR ----
    m1_araddr = 32'h8000_3000; m1_arvalid = 1'b1; m1_rready = 1'b1;
    tick;
    s_arready = 1'b1;
    settle;
    check("t5_grant", 64'(o_grant), 64'd2);
    tick;
    m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rresp = ARB_RESP_SLVERR; s_rdata = 32'h0;
    settle;
    check("t5_m1_rresp", 64'(m1_rresp), 64'(ARB_RESP_SLVERR));
    check("t5_m1_rvalid", 64'(m1_rvalid), 64'd1);
    tick;
    s_rvalid = 1'b0; s_rresp = 2'b00;
    settle;
    check("t5_release", 64'(o_grant), 64'd0);

    // ---- 6: async reset mid IFU_RD ----
    m0_araddr = 32'h8000_000C; m0_arvalid = 1'b1;
    tick;
    settle;
    check("t6_grant", 64'(o_grant), 64'd1);
    check("t6_s_arvalid", 64'(s_arvalid), 64'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t6_async_grant", 64'(o_grant), 64'd0);
    check("t6_async_s_arvalid", 64'(s_arvalid), 64'd0);
    check("t6_async_m0_arready", 64'(m0_arready), 64'd0);
    i_rst_n = 1'b1;
    tick;
    s_arready = 1'b1;
    settle;
    check("t6_regrant", 64'(o_grant), 64'd1);
    check("t6_regrant_addr", 64'(s_araddr), 64'h8000_000C);
    tick;
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
    settle;
    check("t6_m0_rdata", 64'(m0_rdata), 64'hCAFE_0001);
    tick;
    s_rvalid = 1'b0;
    settle;
    check("t6_release", 64'(o_grant), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
